// File: rtl/piano_pkg.sv
// Shared types and note tables for the piano note player.
// Half-periods are derived from FREQ_CHZ at elaboration time.
package piano_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam logic [7:0] NOTE_SILENCE = 8'hFF;
  localparam int NUM_NOTES = 8;

  // C4 D4 E4 F4 G4 A4 B4 C5, in hundredths of a hertz
  localparam int unsigned FREQ_CHZ [NUM_NOTES] = '{
    26163, 29366, 32963, 34923,
    39200, 44000, 49388, 52325
  };

  // 64-bit math: CLK_HZ*100 overflows 32 bits at 100 MHz
  function automatic longint unsigned half_cycles(
    input longint unsigned clk_hz,
    input int idx
  );
    longint unsigned f;
    f = longint'(FREQ_CHZ[idx]);
    return (clk_hz * 100) / (2 * f);
  endfunction

  function automatic longint unsigned max_half(
    input longint unsigned clk_hz
  );
    longint unsigned m;
    m = 0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (half_cycles(clk_hz, i) > m) m = half_cycles(clk_hz, i);
    end
    return m;
  endfunction

endpackage

// File: rtl/piano_note_player_tone_divider.sv
// Square-wave divider: counts to half_period-1, then toggles wave.
// load or !enable clears both counter and wave.
module tone_divider #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] half_period,
  output logic         wave
);

  logic [W-1:0] cnt;

  // Half-period counter and output toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (load || !enable) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (cnt == half_period - W'(1)) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/piano_note_player.sv
// Note byte to buzzer tone player (IDLE/PLAY).
// Optional auto-release: define PIANO_NOTE_HOLD_TIMEOUT_EN.
module piano_note_player
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned HOLD_CYCLES = 150_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] note_data,
  input  logic       note_valid,
  output logic       buzzer,
  output logic       playing,
  output logic [2:0] cur_note,
  output logic       bad_note
);

  localparam int CW = $clog2(max_half(longint'(CLK_HZ))) + 1;

  function automatic logic [NUM_NOTES-1:0][CW-1:0] build_tab();
    logic [NUM_NOTES-1:0][CW-1:0] t;
    for (int i = 0; i < NUM_NOTES; i++) begin
      t[i] = CW'(half_cycles(longint'(CLK_HZ), i));
    end
    return t;
  endfunction

  localparam logic [NUM_NOTES-1:0][CW-1:0] HALF_TAB = build_tab();

  if (HOLD_CYCLES < 1) begin : g_hold_chk
    $error("HOLD_CYCLES must be at least 1");
  end

  state_t     state, state_nx;
  logic [2:0] note_q, note_nx;
  logic       bad_q, bad_nx;
  logic       load;
  logic       legal, silence, timeout, drop;

  assign legal   = note_valid && (note_data < 8'(NUM_NOTES));
  assign silence = note_valid && (note_data == NOTE_SILENCE);
  assign drop    = silence || (timeout && !legal);

`ifdef PIANO_NOTE_HOLD_TIMEOUT_EN
  localparam int TW = $clog2(HOLD_CYCLES) + 1;

  logic [TW-1:0] hold_q;

  assign timeout = (state == PLAY) &&
                   (hold_q == TW'(HOLD_CYCLES - 1));

  // Hold timer: restarts on each legal note, runs only in PLAY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (legal || state_nx != PLAY) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_q + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State, note and bad-byte pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      note_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      note_q <= note_nx;
      bad_q  <= bad_nx;
    end
  end

  // Next state; reload the divider only on a new note
  always_comb begin
    state_nx = state;
    note_nx  = note_q;
    load     = 1'b0;
    bad_nx   = note_valid && !legal && !silence;
    unique case (1'b1)
      legal: begin
        state_nx = PLAY;
        note_nx  = note_data[2:0];
        load     = (state == IDLE) ||
                   (note_data[2:0] != note_q);
      end
      drop: begin
        state_nx = IDLE;
        note_nx  = '0;
      end
      default: ;
    endcase
  end

  tone_divider #(
    .W(CW)
  ) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (state_nx == PLAY),
    .load       (load),
    .half_period(HALF_TAB[note_q]),
    .wave       (buzzer)
  );

  assign playing  = (state == PLAY);
  assign cur_note = note_q;
  assign bad_note = bad_q;

endmodule
